// File: rtl/truth_table_sweeper_if.sv
// Host-side bundle for the truth table sweeper.
// Carries the sweep control inputs and the result outputs.
interface truth_table_sweeper_if;
  logic        start;
  logic        abort;
  logic [15:0] expected;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] table_out;
  logic [4:0]  fail_cnt;
  logic [3:0]  first_fail;

  modport master (
    output start, abort, expected,
    input  busy, done, pass,
    input  table_out, fail_cnt, first_fail
  );

  modport slave (
    input  start, abort, expected,
    output busy, done, pass,
    output table_out, fail_cnt, first_fail
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Drives all 16 vectors into a 4-in/1-out block, builds its
// truth table and compares it against a latched minterm mask.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  truth_table_sweeper_if.slave hif,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  input  logic F
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state;
  state_t      state_nx;
  logic [3:0]  idx;
  logic [3:0]  cnt;
  logic [15:0] exp_q;
  logic [15:0] tbl_q;
  logic [4:0]  fail_q;
  logic [3:0]  ff_q;
  logic        pass_q;
  logic        miss;
  logic [4:0]  fail_nx;
  logic        go;
  logic        busy_o;
  logic        done_o;

  assign go      = hif.start & ~hif.abort;
  assign miss    = F ^ exp_q[idx];
  assign fail_nx = fail_q + {4'b0, miss};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode; abort always wins over start
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: begin
        state_nx = go ? SETTLE : IDLE;
      end
      SETTLE: begin
        if (hif.abort)            state_nx = IDLE;
        else if (cnt == CNT_LAST) state_nx = SAMPLE;
      end
      SAMPLE: begin
        if (hif.abort)       state_nx = IDLE;
        else if (idx == 4'hF) state_nx = DONE;
        else                 state_nx = SETTLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Moore status outputs decoded from the state register
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    unique case (state)
      SETTLE, SAMPLE: busy_o = 1'b1;
      DONE:           done_o = 1'b1;
      default: ;
    endcase
  end

  // Vector index, settle counter and result capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx    <= '0;
      cnt    <= '0;
      exp_q  <= '0;
      tbl_q  <= '0;
      fail_q <= '0;
      ff_q   <= '0;
      pass_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (go) begin
            exp_q  <= hif.expected;
            tbl_q  <= '0;
            fail_q <= '0;
            ff_q   <= '0;
            pass_q <= 1'b0;
            idx    <= '0;
            cnt    <= '0;
          end
        end
        SETTLE: begin
          if (hif.abort) begin
            idx    <= '0;
            cnt    <= '0;
            pass_q <= 1'b0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SAMPLE: begin
          if (hif.abort) begin
            idx    <= '0;
            cnt    <= '0;
            pass_q <= 1'b0;
          end else begin
            tbl_q[idx] <= F;
            fail_q     <= fail_nx;
            if (miss && fail_q == 5'd0) ff_q <= idx;
            cnt <= '0;
            // Final verdict must include this last sample
            if (idx == 4'hF) pass_q <= (fail_nx == 5'd0);
            else             idx    <= idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign {A, B, C, D}   = idx;
  assign hif.busy       = busy_o;
  assign hif.done       = done_o;
  assign hif.pass       = pass_q;
  assign hif.table_out  = tbl_q;
  assign hif.fail_cnt   = fail_q;
  assign hif.first_fail = ff_q;

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

Hardware sequencer that exhaustively exercises a 4-input, 1-output combinational block by driving all 16 input combinations in order. It captures the block's output for each combination into a 16-bit truth table and compares that table against an expected minterm mask. It sits between a host or test controller and the combinational unit under test, and replaces a behavioural sweep loop with synthesizable, self-checking logic.

## Interface

Parameters:
- SETTLE_CYCLES, default 2: cycles inputs are held before F is sampled; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  begin a sweep; accepted only while busy=0.
- abort  input  1  cancel a running sweep.
- expected  input  16  expected truth table; bit i = F for vector i; latched at start.
- A  output  1  DUT input, vector bit 3.
- B  output  1  DUT input, vector bit 2.
- C  output  1  DUT input, vector bit 1.
- D  output  1  DUT input, vector bit 0.
- F  input  1  DUT output.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- pass  output  1  captured table equals latched expected; valid from the done pulse until the next start.
- table_out  output  16  captured truth table; bit i = F sampled for vector i.
- fail_cnt  output  5  number of mismatching vectors, 0..16.
- first_fail  output  4  lowest mismatching vector index; 0 if none.

## Operation

- Reset, when rst_n=0 at an edge:
  - FSM goes to IDLE.
  - A, B, C, D, busy, done and pass are 0.
  - table_out, fail_cnt and first_fail are 0.
  - vector index and settle counter are 0.
- The input vector {A,B,C,D} always equals the registered vector index idx[3:0].
- States:
  - IDLE: busy=0. start=1 and abort=0 → latch expected, clear table_out/fail_cnt/first_fail/pass, idx=0, cnt=0, go to SETTLE.
  - SETTLE: busy=1. cnt increments each cycle. When cnt=SETTLE_CYCLES-1, go to SAMPLE.
  - SAMPLE: busy=1, one cycle. At the end of the cycle:
    - table_out[idx] ← F.
    - If F ≠ expected_latched[idx]: fail_cnt increments. If this is the first mismatch, first_fail ← idx.
    - If idx=15, go to DONE. Otherwise idx increments, cnt=0, go to SETTLE.
  - DONE: busy=0, done=1 for exactly one cycle.
    - pass ← (fail_cnt_final = 0). pass must include the idx=15 result, so compute it from the next-state count, not the stale register.
    - Next state is IDLE. start in DONE is accepted exactly as in IDLE, giving back-to-back sweeps.
- abort=1 while busy=1: next state is IDLE, idx=0, A–D=0, pass=0, no done pulse. table_out and fail_cnt hold the partial results.
- abort=1 and start=1 together in IDLE or DONE: abort wins and start is ignored.
- start while busy=1 is ignored; the running sweep is unaffected.
- expected changes during a sweep have no effect.
- idx does not wrap: sweep ends after vector 15.
- Reset asserted mid-sweep: behaves as full reset at that edge, with no done pulse.

## Timing

- Define t0 as the edge where start is accepted.
- After t0: busy=1 and {A,B,C,D}=0000.
- Each vector occupies SETTLE_CYCLES+1 cycles. F for vector i is sampled at edge t0+(i+1)(SETTLE_CYCLES+1).
- After edge t0+16(SETTLE_CYCLES+1): busy=0, done=1, pass/table_out/fail_cnt/first_fail final.
- One edge later, done=0 and the results hold.
- Total sweep time: 48 cycles with default SETTLE_CYCLES=2; 32 cycles with SETTLE_CYCLES=1.
- Inputs change only on edges. The DUT sees each vector stable for SETTLE_CYCLES+1 cycles before capture.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan

- DUT F=(A&B)|(C&D), expected=16'hF888, SETTLE_CYCLES=2, start pulse at t0 → done=1 exactly 48 cycles after t0, table_out=16'hF888, pass=1, fail_cnt=0, first_fail=0.
- Same DUT, expected=16'hF880 → table_out=16'hF888, pass=0, fail_cnt=1, first_fail=3; expected=16'h0000 → fail_cnt=7, first_fail=3.
- Start a sweep, assert abort at cycle 10 after t0 → next cycle busy=0 and A–D=0. No done pulse ever. pass=0.
- rst_n=0 for one edge at cycle 20 of a sweep → all outputs 0 after that edge. A new start afterwards completes a normal 48-cycle sweep.
- Hold start=1 continuously → start during busy is ignored, and a new sweep begins on the done cycle: busy low for one cycle only, done pulses every 49 cycles. Change expected mid-sweep → result uses the value latched at start.
- SETTLE_CYCLES=1, DUT F=A^B^C^D, expected=16'h6996 → done at 32 cycles, pass=1. Check that each vector is held 2 cycles and visits 0..15 in order.
